// File: rtl/ocimem_arbiter_pkg.sv
// Shared types for the OCI RAM arbiter: FSM states, grant encoding and default widths.
package ocimem_arbiter_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_JTAG = 1'b0,
    GNT_AV   = 1'b1
  } grant_e;

endpackage

// File: rtl/ocimem_rr_pick.sv
// Two-way grant decision: a lone requester wins; ties go to JTAG when forced,
// otherwise to the side that did not win the previous tie.
module ocimem_rr_pick
  import ocimem_arbiter_pkg::*;
(
  input  logic req_j,
  input  logic req_a,
  input  logic last_grant,
  input  logic force_j,
  output logic grant
);

  always_comb begin
    grant = GNT_JTAG;
    if (req_j && req_a) begin
      if (force_j) grant = GNT_JTAG;
      else         grant = ~last_grant;
    end else if (req_a) begin
      grant = GNT_AV;
    end
  end

endmodule

// File: rtl/ocimem_arbiter.sv
// Arbitrates JTAG and Avalon accesses onto the single-port OCI RAM, one access per 3 cycles.
// Optional Avalon write protection above PROT_BASE: define OCIMEM_WRPROT_EN.
module ocimem_arbiter
  import ocimem_arbiter_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] PROT_BASE = 8'h80
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              jtag_req,
  input  logic              jtag_wr,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic [DATA_W-1:0] jtag_wdata,
  output logic              jtag_ack,
  output logic [DATA_W-1:0] jtag_rdata,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [DATA_W-1:0] av_writedata,
  input  logic              av_debugaccess,
  output logic              av_waitrequest,
  output logic [DATA_W-1:0] av_readdata,
  input  logic              debugack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              av_wr_blocked
);

  state_e state;
  logic   gnt, last_grant, wr, blk;
  logic   pend_j, pend_a, grant, nxt_wr, prot_hit;

  // The Avalon command seen while waitrequest is low is the one being completed,
  // so it must not start a second access. The JTAG side drops or replaces
  // jtag_req within its ack cycle.
  assign pend_j = jtag_req;
  assign pend_a = (av_read | av_write) & av_waitrequest;
  assign nxt_wr = (grant == GNT_AV) ? av_write : jtag_wr;

`ifdef OCIMEM_WRPROT_EN
  assign prot_hit = (grant == GNT_AV) && av_write && (av_address >= PROT_BASE) && !av_debugaccess;
`else
  logic unused_cfg;
  assign unused_cfg = ^{av_debugaccess, PROT_BASE};
  assign prot_hit   = 1'b0;
`endif

  ocimem_rr_pick u_pick (
    .req_j      (pend_j),
    .req_a      (pend_a),
    .last_grant (last_grant),
    .force_j    (debugack),
    .grant      (grant)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      gnt            <= GNT_JTAG;
      last_grant     <= GNT_AV;
      wr             <= 1'b0;
      blk            <= 1'b0;
      ram_en         <= 1'b0;
      ram_we         <= 1'b0;
      ram_addr       <= '0;
      ram_wdata      <= '0;
      jtag_ack       <= 1'b0;
      jtag_rdata     <= '0;
      av_readdata    <= '0;
      av_waitrequest <= 1'b1;
      av_wr_blocked  <= 1'b0;
    end else begin
      jtag_ack       <= 1'b0;
      av_waitrequest <= 1'b1;
      av_wr_blocked  <= 1'b0;
      ram_en         <= 1'b0;
      ram_we         <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pend_j || pend_a) begin
            gnt <= grant;
            // only contested decisions move the round-robin pointer
            if (pend_j && pend_a) last_grant <= grant;
            wr        <= nxt_wr;
            blk       <= prot_hit;
            ram_addr  <= (grant == GNT_AV) ? av_address : jtag_addr;
            ram_wdata <= (grant == GNT_AV) ? av_writedata : jtag_wdata;
            ram_en    <= 1'b1;
            ram_we    <= nxt_wr & ~prot_hit;
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: state <= S_DONE;
        S_DONE: begin
          state <= S_IDLE;
          if (gnt == GNT_JTAG) begin
            jtag_ack <= 1'b1;
            if (!wr) jtag_rdata <= ram_rdata;
          end else begin
            av_waitrequest <= 1'b0;
            av_wr_blocked  <= blk;
            if (!wr) av_readdata <= ram_rdata;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ocimem_arbiter.sv
// Self-checking bench for ocimem_arbiter: table vectors, corner sequences and random ops
// checked against a transaction-level model (honours OCIMEM_WRPROT_EN when defined).
module tb_ocimem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
`ifdef OCIMEM_WRPROT_EN
  localparam bit PROT_ON = 1'b1;
`else
  localparam bit PROT_ON = 1'b0;
`endif

  logic clk = 1'b0, reset_n = 1'b1;
  logic jtag_req = 1'b0, jtag_wr = 1'b0;
  logic [AW-1:0] jtag_addr = '0, av_address = '0;
  logic [DW-1:0] jtag_wdata = '0, av_writedata = '0;
  logic av_read = 1'b0, av_write = 1'b0, av_debugaccess = 1'b0, debugack = 1'b0;
  logic jtag_ack, av_waitrequest, ram_en, ram_we, av_wr_blocked;
  logic [DW-1:0] jtag_rdata, av_readdata, ram_wdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rdata = '0;
  logic [DW-1:0] ram [0:255] = '{default: '0};

  int total = 0, bad = 0;

  ocimem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .jtag_req(jtag_req), .jtag_wr(jtag_wr), .jtag_addr(jtag_addr), .jtag_wdata(jtag_wdata),
    .jtag_ack(jtag_ack), .jtag_rdata(jtag_rdata),
    .av_address(av_address), .av_read(av_read), .av_write(av_write),
    .av_writedata(av_writedata), .av_debugaccess(av_debugaccess),
    .av_waitrequest(av_waitrequest), .av_readdata(av_readdata),
    .debugack(debugack),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .av_wr_blocked(av_wr_blocked)
  );

  always #5 clk = ~clk;

  // single-port RAM, one-cycle read latency
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
    end
  end

  typedef struct {
    bit jv, jw; logic [7:0] ja; logic [31:0] jd;
    bit avv, aw, ard; logic [7:0] aa; logic [31:0] ad;
    bit dbg, adbg;
  } op_t;
  typedef struct { op_t op; int ejc, eac; logic [31:0] ejr, ear; } vec_t;

  // reference model: memory image, who won the most recent tie, held read data
  logic [31:0] ref_mem [0:255] = '{default: '0};
  bit          m_last_av;
  logic [31:0] m_jr, m_ar;
  vec_t        tbl [8];

  function automatic op_t mkop(bit jv, bit jw, logic [7:0] ja, logic [31:0] jd,
                               bit avv, bit aw, bit ard, logic [7:0] aa, logic [31:0] ad,
                               bit dbg, bit adbg);
    op_t o;
    o.jv = jv; o.jw = jw; o.ja = ja; o.jd = jd;
    o.avv = avv; o.aw = aw; o.ard = ard; o.aa = aa; o.ad = ad;
    o.dbg = dbg; o.adbg = adbg;
    return o;
  endfunction

  function automatic vec_t mkv(op_t o, int ejc, int eac, logic [31:0] ejr, logic [31:0] ear);
    vec_t v;
    v.op = o; v.ejc = ejc; v.eac = eac; v.ejr = ejr; v.ear = ear;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_rst(input string p);
    chk({p, "_ram_en"}, 32'(ram_en), 0);
    chk({p, "_ram_we"}, 32'(ram_we), 0);
    chk({p, "_ram_addr"}, 32'(ram_addr), 0);
    chk({p, "_ram_wdata"}, ram_wdata, 0);
    chk({p, "_jtag_ack"}, 32'(jtag_ack), 0);
    chk({p, "_jtag_rdata"}, jtag_rdata, 0);
    chk({p, "_av_readdata"}, av_readdata, 0);
    chk({p, "_av_waitrequest"}, 32'(av_waitrequest), 1);
    chk({p, "_av_wr_blocked"}, 32'(av_wr_blocked), 0);
  endtask

  task automatic m_reset();
    m_last_av = 1'b1; m_jr = '0; m_ar = '0;
  endtask

  task automatic idle_inputs();
    jtag_req = 1'b0; av_read = 1'b0; av_write = 1'b0; debugack = 1'b0; av_debugaccess = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    #1 chk_rst("rst");
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    m_reset();
  endtask

  // one transaction pair: model predicts order, latency, data and RAM side effects
  task automatic do_op(input op_t o, output int jc, output int ac);
    int n, we_cnt, blk_cnt, wlow, jack, exp_jc, exp_ac, exp_we, exp_blk;
    bit j_first, jdone, adone, sj;
    if (o.jv && o.avv) begin
      j_first   = o.dbg || m_last_av;
      m_last_av = !j_first;
    end else j_first = o.jv;
    exp_jc = o.jv  ? ((o.avv && !j_first) ? 6 : 3) : 0;
    exp_ac = o.avv ? ((o.jv && j_first) ? 6 : 3) : 0;
    exp_we = 0; exp_blk = 0;
    for (int k = 0; k < 2; k++) begin
      sj = (k == 0) ? j_first : !j_first;
      if (sj && o.jv) begin
        if (o.jw) begin ref_mem[o.ja] = o.jd; exp_we++; end
        else m_jr = ref_mem[o.ja];
      end
      if (!sj && o.avv) begin
        if (o.aw) begin
          if (PROT_ON && o.aa >= 8'h80 && !o.adbg) exp_blk++;
          else begin ref_mem[o.aa] = o.ad; exp_we++; end
        end else m_ar = ref_mem[o.aa];
      end
    end

    @(negedge clk);
    for (int g = 0; g < 4 && !av_waitrequest; g++) @(negedge clk);
    jtag_req = o.jv; jtag_wr = o.jw; jtag_addr = o.ja; jtag_wdata = o.jd;
    av_read = o.avv && (!o.aw || o.ard); av_write = o.avv && o.aw;
    av_address = o.aa; av_writedata = o.ad; av_debugaccess = o.adbg; debugack = o.dbg;
    jc = 0; ac = 0; jdone = !o.jv; adone = !o.avv;
    n = 0; we_cnt = 0; blk_cnt = 0; wlow = 0; jack = 0;
    while (!(jdone && adone) && n < 12) begin
      @(posedge clk); #1; n++;
      we_cnt  += int'(ram_en && ram_we);
      blk_cnt += int'(av_wr_blocked);
      wlow    += int'(!av_waitrequest);
      jack    += int'(jtag_ack);
      if (jtag_ack && !jdone) begin jc = n; jdone = 1'b1; jtag_req = 1'b0; end
      if (!av_waitrequest && !adone) begin ac = n; adone = 1'b1; av_read = 1'b0; av_write = 1'b0; end
    end
    chk("jtag_latency", jc, exp_jc);
    chk("av_latency", ac, exp_ac);
    chk("jtag_rdata", jtag_rdata, m_jr);
    chk("av_readdata", av_readdata, m_ar);
    chk("ram_we_count", we_cnt, exp_we);
    chk("wr_blocked_count", blk_cnt, exp_blk);
    chk("jtag_ack_count", jack, 32'(o.jv));
    chk("av_wait_low_count", wlow, 32'(o.avv));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int jc, ac, n, served, last, wlow, cnt;
    logic [7:0]  da [4];
    logic [31:0] de [4];
    op_t o;

    #1 do_reset();

    // JTAG write then read back
    do_op(mkop(1, 1, 8'h10, 32'h12345678, 0, 0, 0, 8'h00, 0, 0, 0), jc, ac);
    chk("hs_wr_ack_cycle", jc, 3);
    do_op(mkop(1, 0, 8'h10, 0, 0, 0, 0, 8'h00, 0, 0, 0), jc, ac);
    chk("hs_rd_ack_cycle", jc, 3);
    chk("hs_rd_data", jtag_rdata, 32'h12345678);

    // vectors assume a fresh reset: first tie goes to JTAG
    tbl[0] = mkv(mkop(1, 1, 8'h10, 32'h12345678, 1, 0, 0, 8'h20, 0, 0, 0), 3, 6, 32'h0, 32'h0);
    tbl[1] = mkv(mkop(1, 0, 8'h10, 0, 1, 1, 1, 8'h10, 32'hAAAA5555, 0, 0), 6, 3, 32'hAAAA5555, 32'h0);
    tbl[2] = mkv(mkop(1, 0, 8'h20, 0, 0, 0, 0, 8'h00, 0, 0, 0), 3, 0, 32'h0, 32'h0);
    tbl[3] = mkv(mkop(1, 0, 8'h10, 0, 1, 0, 0, 8'h10, 0, 1, 0), 3, 6, 32'hAAAA5555, 32'hAAAA5555);
    tbl[4] = mkv(mkop(1, 0, 8'h7F, 0, 1, 1, 0, 8'h7F, 32'h0BADF00D, 0, 0), 6, 3, 32'h0BADF00D, 32'hAAAA5555);
    tbl[5] = mkv(mkop(1, 1, 8'hFF, 32'hCAFEF00D, 0, 0, 0, 8'h00, 0, 0, 0), 3, 0, 32'h0BADF00D, 32'hAAAA5555);
    tbl[6] = mkv(mkop(0, 0, 8'h00, 0, 1, 0, 0, 8'hFF, 0, 0, 0), 0, 3, 32'h0BADF00D, 32'hCAFEF00D);
    tbl[7] = mkv(mkop(0, 0, 8'h00, 0, 1, 0, 0, 8'h20, 0, 0, 0), 0, 3, 32'h0BADF00D, 32'h0);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].op, jc, ac);
      chk($sformatf("tbl%0d_jtag_cycle", i), jc, tbl[i].ejc);
      chk($sformatf("tbl%0d_av_cycle", i), ac, tbl[i].eac);
      chk($sformatf("tbl%0d_jtag_rdata", i), jtag_rdata, tbl[i].ejr);
      chk($sformatf("tbl%0d_av_readdata", i), av_readdata, tbl[i].ear);
    end

    // debugack: JTAG back-to-back starves a waiting Avalon read
    da[0] = 8'h10; da[1] = 8'hFF; da[2] = 8'h7F; da[3] = 8'h20;
    de[0] = 32'hAAAA5555; de[1] = 32'hCAFEF00D; de[2] = 32'h0BADF00D; de[3] = 32'h0;
    do_reset();
    debugack = 1'b1; av_read = 1'b1; av_address = 8'h7F;
    jtag_req = 1'b1; jtag_wr = 1'b0; jtag_addr = da[0];
    served = 0; wlow = 0; n = 0; last = 0;
    while (served < 4 && n < 40) begin
      @(posedge clk); #1; n++;
      wlow += int'(!av_waitrequest);
      if (jtag_ack) begin
        chk("dbg_ack_spacing", n - last, 3);
        chk("dbg_rdata", jtag_rdata, de[served]);
        last = n; served++;
        if (served < 4) jtag_addr = da[served];
        else jtag_req = 1'b0;
      end
    end
    chk("dbg_served", served, 4);
    chk("dbg_av_wait_low", wlow, 0);
    n = 0;
    while (av_waitrequest && n < 10) begin @(posedge clk); #1; n++; end
    chk("dbg_av_cycle", n, 3);
    chk("dbg_av_readdata", av_readdata, 32'h0BADF00D);
    av_read = 1'b0; debugack = 1'b0;
    do_reset();

    // protected Avalon write, then privileged write
    do_op(mkop(0, 0, 0, 0, 1, 1, 0, 8'h80, 32'hDEADBEEF, 0, 0), jc, ac);
    do_op(mkop(1, 0, 8'h80, 0, 0, 0, 0, 0, 0, 0, 0), jc, ac);
    chk("wp_readback", jtag_rdata, PROT_ON ? 32'h0 : 32'hDEADBEEF);
    do_op(mkop(0, 0, 0, 0, 1, 1, 0, 8'h80, 32'hDEADBEEF, 0, 1), jc, ac);
    do_op(mkop(1, 0, 8'h80, 0, 0, 0, 0, 0, 0, 0, 0), jc, ac);
    chk("wp_dbg_readback", jtag_rdata, 32'hDEADBEEF);

    // reset during ACCESS of a JTAG write
    do_op(mkop(1, 1, 8'h30, 32'h11111111, 0, 0, 0, 0, 0, 0, 0), jc, ac);
    @(negedge clk);
    jtag_req = 1'b1; jtag_wr = 1'b1; jtag_addr = 8'h30; jtag_wdata = 32'h55AA55AA;
    @(posedge clk); #1;
    chk("ra_access_en", 32'(ram_en), 1);
    chk("ra_access_we", 32'(ram_we), 1);
    #2 reset_n = 1'b0; jtag_req = 1'b0;
    #1 chk_rst("ra");
    cnt = 0;
    repeat (3) begin @(posedge clk); #1; cnt += int'(jtag_ack || ram_en); end
    chk("ra_quiet_in_reset", cnt, 0);
    @(negedge clk) reset_n = 1'b1;
    m_reset();
    @(posedge clk); #1;
    chk("ra_wait_after", 32'(av_waitrequest), 1);
    chk("ra_ack_after", 32'(jtag_ack), 0);
    do_op(mkop(1, 0, 8'h30, 0, 0, 0, 0, 0, 0, 0, 0), jc, ac);
    chk("ra_readback", jtag_rdata, 32'h11111111);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      o.jv   = 1'($urandom_range(0, 1));
      o.avv  = o.jv ? 1'($urandom_range(0, 1)) : 1'b1;
      o.jw   = 1'($urandom_range(0, 1));
      o.aw   = 1'($urandom_range(0, 1));
      o.ard  = 1'($urandom_range(0, 1));
      o.ja   = 8'($urandom_range(0, 3)) | ($urandom_range(0, 1) ? 8'h80 : 8'h00);
      o.aa   = 8'($urandom_range(0, 3)) | ($urandom_range(0, 1) ? 8'h80 : 8'h00);
      o.jd   = $urandom;
      o.ad   = $urandom;
      o.dbg  = 1'($urandom_range(0, 1));
      o.adbg = 1'($urandom_range(0, 1));
      do_op(o, jc, ac);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ocimem_arbiter.md
OCIMEM_ARBITER -- requirements
Module: ocimem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 8, OCI RAM word-address width; DATA_W, default 32, data width; PROT_BASE, default 8'h80, lowest address that is write-protected from Avalon.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- jtag_req  in  1  JTAG-side request level, held until jtag_ack.
- jtag_wr  in  1  1 = write, 0 = read.
- jtag_addr  in  ADDR_W  JTAG word address.
- jtag_wdata  in  DATA_W  JTAG write data.
- jtag_ack  out  1  one-cycle completion pulse.
- jtag_rdata  out  DATA_W  read data, valid with jtag_ack, held until next JTAG read.
- av_address  in  ADDR_W  Avalon word address.
- av_read  in  1  Avalon read.
- av_write  in  1  Avalon write.
- av_writedata  in  DATA_W  Avalon write data.
- av_debugaccess  in  1  privileged access qualifier.
- av_waitrequest  out  1  Avalon stall.
- av_readdata  out  DATA_W  valid when av_waitrequest = 0 on a read.
- debugack  in  1  CPU halted in debug; gives JTAG fixed priority.
- ram_en  out  1  RAM access enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, one-cycle latency after ram_en.
- av_wr_blocked  out  1  pulse: protected Avalon write dropped.

Function
REQ-003 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE; all outputs SHALL be registered.
REQ-004 In IDLE, on any pending request, SHALL latch grant, address, data and direction, then enter ACCESS next cycle.
REQ-005 In ACCESS, SHALL drive ram_en = 1, ram_addr, ram_wdata and ram_we = write for exactly one cycle.
REQ-006 In DONE, SHALL capture ram_rdata for reads and signal completion:
- JTAG grant: jtag_ack = 1 for one cycle.
- Avalon grant: av_waitrequest = 0 for one cycle.
REQ-007 Latency SHALL be fixed at 3 cycles from request sampled in IDLE to completion; throughput SHALL be one access per 3 cycles.
REQ-008 av_waitrequest SHALL be 1 in every cycle except the Avalon DONE cycle.
REQ-009 Arbitration when both requesters are pending in IDLE:
- debugack = 1: JTAG wins.
- debugack = 0: round-robin against a last_grant register.
- A single pending requester always wins.
REQ-010 av_read and av_write both asserted SHALL be treated as a write.
REQ-011 Request inputs SHALL be ignored outside IDLE; changes after latch SHALL NOT affect the access in flight.
REQ-012 Write completions SHALL leave jtag_rdata/av_readdata unchanged.

Reset
REQ-013 While reset_n = 0, asynchronously:
- state = IDLE, last_grant = Avalon (JTAG wins first tie).
- ram_en = ram_we = 0; ram_addr, ram_wdata = 0.
- jtag_ack = 0, jtag_rdata = 0, av_readdata = 0, av_wr_blocked = 0.
- av_waitrequest = 1.
REQ-014 Reset mid-access SHALL abort the access with no ack and no RAM write after reset_n asserts.

Configuration
REQ-015 Macro OCIMEM_WRPROT_EN:
- Defined: an Avalon write with address >= PROT_BASE and av_debugaccess = 0 SHALL complete normally (same timing) with ram_we = 0, and SHALL pulse av_wr_blocked in DONE.
- Undefined: all writes pass and av_wr_blocked is tied 0.
- JTAG writes are never protected.

Structure
REQ-016 State enum, grant encoding and default widths SHALL live in shared package ocimem_arbiter_pkg.
REQ-017 Round-robin decision SHALL be sub-module ocimem_rr_pick (inputs req_j, req_a, last_grant, force_j; output grant); no other sub-modules.

Verification
REQ-018 Bench SHALL cover:
- JTAG write 0x12345678 to addr 0x10, then read -> jtag_ack on cycle 3 of each access; jtag_rdata = 0x12345678.
- Simultaneous JTAG and Avalon reads with debugack = 0, first after reset -> JTAG served first, Avalon completes 3 cycles later; repeat the tie -> Avalon first.
- debugack = 1 with continuous requests from both -> JTAG served every time; av_waitrequest stays 1.
- With OCIMEM_WRPROT_EN, Avalon write 0xDEADBEEF to 0x80 with av_debugaccess = 0 -> av_wr_blocked pulse, ram_we never 1, JTAG readback unchanged; repeat with av_debugaccess = 1 -> write lands.
- reset_n asserted during ACCESS of a JTAG write -> no jtag_ack, all outputs at reset values; after release, state is IDLE and av_waitrequest = 1.
